// File: rtl/cache_pkg.sv
// Shared types and line-geometry helpers for the cache slice.
// Used by the line adapter and the cache data arrays.
package cache_pkg;

  localparam int WORD_W_DEF     = 32;
  localparam int LINE_WORDS_DEF = 8;
  localparam int ADDR_W_DEF     = 32;
  localparam int LINE_W_DEF     = WORD_W_DEF * LINE_WORDS_DEF;
  localparam int BEAT_W_DEF     = $clog2(LINE_WORDS_DEF);

  typedef enum logic [1:0] {
    IDLE,
    WR_BURST,
    RD_BURST,
    RESP
  } adapter_state_e;

  function automatic int line_bytes(
    input int words,
    input int word_w
  );
    return words * word_w / 8;
  endfunction

  function automatic int offset_bits(
    input int words,
    input int word_w
  );
    return $clog2(line_bytes(words, word_w));
  endfunction

  function automatic logic [WORD_W_DEF-1:0] word_sel(
    input logic [LINE_W_DEF-1:0] line,
    input logic [BEAT_W_DEF-1:0] idx
  );
    return line[int'(idx)*WORD_W_DEF +: WORD_W_DEF];
  endfunction

endpackage

// File: rtl/cache_line_adapter_if.sv
// Controller-side and main-memory-side signals of the line adapter.
// master = controller/memory side, slave = adapter.
interface cache_line_adapter_if
  import cache_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
);

  logic                         mem_read;
  logic                         mem_write;
  logic [ADDR_W-1:0]            line_addr;
  logic [LINE_WORDS*WORD_W-1:0] line_wdata;
  logic                         ca_resp;
  logic [LINE_WORDS*WORD_W-1:0] line_rdata;
  logic                         busy;
  logic [ADDR_W-1:0]            mm_addr;
  logic [WORD_W-1:0]            mm_wdata;
  logic                         mm_we;
  logic                         mm_re;
  logic                         mm_ack;
  logic [WORD_W-1:0]            mm_rdata;

  modport master (
    output mem_read, mem_write,
    output line_addr, line_wdata,
    output mm_ack, mm_rdata,
    input  ca_resp, line_rdata, busy,
    input  mm_addr, mm_wdata,
    input  mm_we, mm_re
  );

  modport slave (
    input  mem_read, mem_write,
    input  line_addr, line_wdata,
    input  mm_ack, mm_rdata,
    output ca_resp, line_rdata, busy,
    output mm_addr, mm_wdata,
    output mm_we, mm_re
  );

endinterface

// File: rtl/cache_line_adapter.sv
// Splits a cache-line refill/writeback into sequential word beats
// on the main-memory port and pulses ca_resp when the line is done.
module cache_line_adapter
  import cache_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input logic                clk,
  input logic                rst,
  cache_line_adapter_if.slave bus
);

  localparam int BW = $clog2(LINE_WORDS);
  localparam int LW = LINE_WORDS * WORD_W;
  localparam int OB = offset_bits(LINE_WORDS, WORD_W);
  localparam int WB = OB - BW;

  adapter_state_e    state_q;
  adapter_state_e    state_d;
  logic [BW-1:0]     beat_q;
  logic [ADDR_W-1:0] base_q;
  logic [LW-1:0]     wbuf_q;
  logic [LW-1:0]     rbuf_q;
  logic [ADDR_W-1:0] beat_off;
  logic              last_beat;
  logic [ADDR_W-1:0] base_in;

  assign beat_off  = {{(ADDR_W-OB){1'b0}}, beat_q, {WB{1'b0}}};
  assign last_beat = beat_q == BW'(LINE_WORDS - 1);
  assign base_in   = {bus.line_addr[ADDR_W-1:OB], {OB{1'b0}}};

  // State register; reset aborts any burst immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and memory/controller strobes from registered state.
  always_comb begin
    state_d      = state_q;
    bus.ca_resp  = 1'b0;
    bus.busy     = 1'b1;
    bus.mm_we    = 1'b0;
    bus.mm_re    = 1'b0;
    bus.mm_addr  = '0;
    bus.mm_wdata = '0;
    unique case (state_q)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.mem_write)     state_d = WR_BURST;
        else if (bus.mem_read) state_d = RD_BURST;
      end
      WR_BURST: begin
        bus.mm_we    = 1'b1;
        bus.mm_addr  = base_q | beat_off;
        bus.mm_wdata = word_sel(wbuf_q, beat_q);
        if (bus.mm_ack && last_beat) state_d = RESP;
      end
      RD_BURST: begin
        bus.mm_re   = 1'b1;
        bus.mm_addr = base_q | beat_off;
        if (bus.mm_ack && last_beat) state_d = RESP;
      end
      RESP: begin
        bus.ca_resp = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, beat counter and refill line buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_q <= '0;
      base_q <= '0;
      wbuf_q <= '0;
      rbuf_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.mem_write) begin
            base_q <= base_in;
            wbuf_q <= bus.line_wdata;
            beat_q <= '0;
          end else if (bus.mem_read) begin
            base_q <= base_in;
            beat_q <= '0;
          end
        end
        WR_BURST: begin
          if (bus.mm_ack) beat_q <= beat_q + BW'(1);
        end
        RD_BURST: begin
          if (bus.mm_ack) begin
            rbuf_q[int'(beat_q)*WORD_W +: WORD_W] <= bus.mm_rdata;
            beat_q <= beat_q + BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.line_rdata = rbuf_q;

endmodule

// File: tb/tb_cache_line_adapter.sv
// Directed bench for cache_line_adapter with a beat scoreboard.
// Expected beats are queued at request time, popped on mm_ack.
module tb_cache_line_adapter;

  logic clk;
  logic rst;

  cache_line_adapter_if bus ();

  cache_line_adapter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];

  task automatic check(
    input string        tag,
    input logic [255:0] obs,
    input logic [255:0] exp
  );
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] b);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = b + 32'(i);
    return l;
  endfunction

  task automatic push_line(
    input logic [31:0]  addr,
    input logic [255:0] line
  );
    logic [31:0] base;
    base = {addr[31:5], 5'b0};
    for (int i = 0; i < 8; i++) begin
      q_addr.push_back(base + 32'(i*4));
      q_data.push_back(line[i*32 +: 32]);
    end
  endtask

  // Entered one #1 after the accepting edge (cycle 1 of the burst).
  // Returns at the negedge of the ca_resp cycle, or early on abort.
  task automatic run_burst(
    input  bit          wr,
    input  int          period,
    input  logic [31:0] rd_base,
    input  int          abort_beats,
    output int          resp_cycle
  );
    int beats;
    beats = 0;
    resp_cycle = -1;
    for (int k = 1; k <= 400; k++) begin
      if (abort_beats >= 0 && beats == abort_beats) begin
        bus.mm_ack = 1'b0;
        return;
      end
      bus.mm_ack   = ((k - 1) % period) == period - 1;
      bus.mm_rdata = rd_base + 32'(beats);
      @(negedge clk);
      if (q_addr.size() == 0) begin
        check("resp_pulse", 256'(bus.ca_resp), 256'(1));
        resp_cycle = k;
        bus.mm_ack = 1'b0;
        return;
      end
      if (wr) check("we", 256'(bus.mm_we), 256'(1));
      else    check("re", 256'(bus.mm_re), 256'(1));
      check("no_both", 256'(bus.mm_we & bus.mm_re), 256'(0));
      check("no_resp_mid", 256'(bus.ca_resp), 256'(0));
      check("addr", 256'(bus.mm_addr), 256'(q_addr[0]));
      if (wr) check("wdata", 256'(bus.mm_wdata), 256'(q_data[0]));
      if (bus.mm_ack) begin
        void'(q_addr.pop_front());
        void'(q_data.pop_front());
        beats++;
      end
      @(posedge clk);
      #1;
    end
    bus.mm_ack = 1'b0;
  endtask

  int           rc;
  logic [255:0] exp_rd;

  initial begin
    rst            = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.line_addr  = '0;
    bus.line_wdata = '0;
    bus.mm_ack     = 1'b0;
    bus.mm_rdata   = '0;

    // Reset values.
    #1;
    check("rst_resp", 256'(bus.ca_resp), 256'(0));
    check("rst_busy", 256'(bus.busy), 256'(0));
    check("rst_we", 256'(bus.mm_we), 256'(0));
    check("rst_re", 256'(bus.mm_re), 256'(0));
    check("rst_addr", 256'(bus.mm_addr), 256'(0));
    check("rst_wdata", 256'(bus.mm_wdata), 256'(0));
    check("rst_rdata", bus.line_rdata, 256'(0));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_strobe", 256'(bus.mm_we | bus.mm_re), 256'(0));
      check("idle_busy", 256'(bus.busy), 256'(0));
      check("idle_resp", 256'(bus.ca_resp), 256'(0));
    end
    @(posedge clk);
    #1;

    // Zero-wait refill.
    bus.mem_read  = 1'b1;
    bus.line_addr = 32'h0000_1234;
    push_line(32'h0000_1234, '0);
    exp_rd = mk_line(32'h1000);
    @(posedge clk);
    #1;
    bus.mem_read = 1'b0;
    run_burst(1'b0, 1, 32'h1000, -1, rc);
    check("refill_resp_cycle", 256'(rc), 256'(9));
    check("refill_line", bus.line_rdata, exp_rd);
    @(posedge clk);
    #1;
    check("refill_resp_drop", 256'(bus.ca_resp), 256'(0));
    check("refill_idle", 256'(bus.busy), 256'(0));

    // Wait-state writeback, ack every 3rd cycle.
    bus.mem_write  = 1'b1;
    bus.line_addr  = 32'h0000_0040;
    bus.line_wdata = mk_line(32'hA0);
    push_line(32'h0000_0040, mk_line(32'hA0));
    @(posedge clk);
    #1;
    bus.mem_write = 1'b0;
    run_burst(1'b1, 3, '0, -1, rc);
    check("wb_resp_cycle", 256'(rc), 256'(25));
    check("wb_keeps_rdata", bus.line_rdata, exp_rd);
    @(posedge clk);
    #1;
    check("wb_resp_drop", 256'(bus.ca_resp), 256'(0));

    // Simultaneous request: write first, then read.
    bus.mem_write  = 1'b1;
    bus.mem_read   = 1'b1;
    bus.line_addr  = 32'h0000_2010;
    bus.line_wdata = mk_line(32'hB0);
    push_line(32'h0000_2010, mk_line(32'hB0));
    @(posedge clk);
    #1;
    bus.mem_write = 1'b0;
    run_burst(1'b1, 1, '0, -1, rc);
    check("both_wr_resp", 256'(rc), 256'(9));
    @(posedge clk);
    #1;
    check("both_idle", 256'(bus.busy), 256'(0));
    push_line(32'h0000_2010, '0);
    exp_rd = mk_line(32'h5000);
    @(posedge clk);
    #1;
    bus.mem_read = 1'b0;
    run_burst(1'b0, 1, 32'h5000, -1, rc);
    check("both_rd_resp", 256'(rc), 256'(9));
    check("both_rd_line", bus.line_rdata, exp_rd);
    @(posedge clk);
    #1;

    // Reset after beat 3 of a refill.
    bus.mem_read  = 1'b1;
    bus.line_addr = 32'h0000_3000;
    push_line(32'h0000_3000, '0);
    @(posedge clk);
    #1;
    bus.mem_read = 1'b0;
    run_burst(1'b0, 1, 32'h7000, 4, rc);
    check("pre_abort_re", 256'(bus.mm_re), 256'(1));
    rst = 1'b0;
    #1;
    check("abort_re", 256'(bus.mm_re), 256'(0));
    check("abort_busy", 256'(bus.busy), 256'(0));
    check("abort_rdata", bus.line_rdata, 256'(0));
    q_addr.delete();
    q_data.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_no_resp", 256'(bus.ca_resp), 256'(0));
    end
    @(posedge clk);
    #1;
    bus.mem_read = 1'b1;
    push_line(32'h0000_3000, '0);
    exp_rd = mk_line(32'h7100);
    @(posedge clk);
    #1;
    bus.mem_read = 1'b0;
    run_burst(1'b0, 1, 32'h7100, -1, rc);
    check("restart_resp", 256'(rc), 256'(9));
    check("restart_line", bus.line_rdata, exp_rd);
    @(posedge clk);
    #1;

    // mem_write held through RESP.
    bus.mem_write  = 1'b1;
    bus.line_addr  = 32'h0000_0080;
    bus.line_wdata = mk_line(32'hC0);
    push_line(32'h0000_0080, mk_line(32'hC0));
    @(posedge clk);
    #1;
    run_burst(1'b1, 1, '0, -1, rc);
    check("hold_resp1", 256'(rc), 256'(9));
    @(posedge clk);
    #1;
    check("hold_pulse", 256'(bus.ca_resp), 256'(0));
    check("hold_idle", 256'(bus.busy), 256'(0));
    push_line(32'h0000_0080, mk_line(32'hC0));
    @(posedge clk);
    #1;
    bus.mem_write = 1'b0;
    run_burst(1'b1, 1, '0, -1, rc);
    check("hold_resp2", 256'(rc), 256'(9));
    @(posedge clk);
    #1;
    check("hold_end_idle", 256'(bus.busy), 256'(0));
    check("hold_end_resp", 256'(bus.ca_resp), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
